// File: rtl/result_drain_23_pkg.sv
// Shared constants for the result drain: word width, layer codes, RAM region
// bases and the drain FSM state encoding.
package result_drain_23_pkg;

    localparam int DATA_LEN = 16;

    localparam logic [3:0] LAYER0 = 4'h0;
    localparam logic [3:0] LAYER1 = 4'h1;
    localparam logic [3:0] LAYER2 = 4'h2;
    localparam logic [3:0] LAYER3 = 4'h3;
    localparam logic [3:0] AFFINE = 4'h4;

    // Region bases are also used by the weight-store address logic.
    localparam int LAYER0_BASE = 0;
    localparam int LAYER1_BASE = 288;
    localparam int LAYER2_BASE = 576;
    localparam int LAYER3_BASE = 864;
    localparam int AFFINE_BASE = 1152;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } drain_state_e;

endpackage

// File: rtl/layer_base_dec_23.sv
// Combinational decode of a layer code into its RAM region base address.
// Unknown codes give base 0 with valid_code low.
module layer_base_dec_23
    import result_drain_23_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic [3:0]        cs,
    output logic [ADDR_W-1:0] base,
    output logic              valid_code
);

    always_comb begin
        base       = '0;
        valid_code = 1'b1;
        case (cs)
            LAYER0:  base = ADDR_W'(LAYER0_BASE);
            LAYER1:  base = ADDR_W'(LAYER1_BASE);
            LAYER2:  base = ADDR_W'(LAYER2_BASE);
            LAYER3:  base = ADDR_W'(LAYER3_BASE);
            AFFINE:  base = ADDR_W'(AFFINE_BASE);
            default: valid_code = 1'b0;
        endcase
    end

endmodule

// File: rtl/result_drain_23.sv
// Captures a wide result vector on start and writes it word by word into the
// layer's RAM region, pulsing done after the final write.
//
// state    | meaning
// ST_IDLE  | waiting for start with a valid layer code
// ST_WRITE | one RAM write per cycle, shadow[idx] -> base+idx
// ST_DONE  | final write issued; done pulses next cycle
module result_drain_23
    import result_drain_23_pkg::*;
#(
    parameter int WORDS  = 288,
    parameter int ADDR_W = 11
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [3:0]                cs,
    input  logic                      start,
    input  logic [WORDS*DATA_LEN-1:0] d,
    output logic                      busy,
    output logic                      done,
    output logic                      we,
    output logic [ADDR_W-1:0]         addr,
    output logic [DATA_LEN-1:0]       wdata
);

    localparam int IDX_W = 9;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    drain_state_e          state_q;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      idx_d;
    logic [ADDR_W-1:0]     base_q;
    logic [ADDR_W-1:0]     addr_d;
    logic                  busy_q;
    logic                  done_q;
    logic                  we_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_LEN-1:0]   wdata_q;
    logic [DATA_LEN-1:0]   shadow_q [WORDS];

    logic [ADDR_W-1:0]     dec_base;
    logic                  dec_valid;
    logic                  capture;

    layer_base_dec_23 #(
        .ADDR_W(ADDR_W)
    ) u_base_dec (
        .cs        (cs),
        .base      (dec_base),
        .valid_code(dec_valid)
    );

    assign capture = (state_q == ST_IDLE) && start && dec_valid;
    assign idx_d   = idx_q + IDX_W'(1);
    assign addr_d  = base_q + ADDR_W'(idx_q);

    // Shadow holds data only; its contents are meaningless until captured.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < WORDS; i++) begin
                shadow_q[i] <= d[i*DATA_LEN +: DATA_LEN];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (capture) begin
                        base_q  <= dec_base;
                        idx_q   <= '0;
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    we_q    <= 1'b1;
                    busy_q  <= 1'b1;
                    addr_q  <= addr_d;
                    wdata_q <= shadow_q[idx_q];
                    idx_q   <= idx_d;
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign we    = we_q;
    assign addr  = addr_q;
    assign wdata = wdata_q;

endmodule

// File: tb/tb_result_drain_23.sv
// Scoreboard bench for result_drain_23: stimulus pushes expected writes and
// done pulses tagged with their cycle; a negedge monitor pops and compares.
module tb_result_drain_23;
    import result_drain_23_pkg::*;

    localparam int WORDS  = 288;
    localparam int ADDR_W = 11;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic [3:0]                cs = 4'h0;
    logic                      start = 1'b0;
    logic [WORDS*DATA_LEN-1:0] d = '0;
    logic                      busy;
    logic                      done;
    logic                      we;
    logic [ADDR_W-1:0]         addr;
    logic [DATA_LEN-1:0]       wdata;

    result_drain_23 #(
        .WORDS (WORDS),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .cs   (cs),
        .start(start),
        .d    (d),
        .busy (busy),
        .done (done),
        .we   (we),
        .addr (addr),
        .wdata(wdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit                  is_done;
        int                  cyc;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_LEN-1:0] data;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DATA_LEN-1:0] pat(input int p, input int i);
        case (p)
            0:       return DATA_LEN'(i);
            1:       return DATA_LEN'(i * 37 + 'h1234);
            2:       return DATA_LEN'(i) ^ 16'hA5A5;
            default: return ~DATA_LEN'(i * 5);
        endcase
    endfunction

    task automatic fill_d(input int p);
        for (int i = 0; i < WORDS; i++) d[i*DATA_LEN +: DATA_LEN] = pat(p, i);
    endtask

    // Drives start now (sampled at the next edge). base < 0 means no writes expected.
    task automatic issue(input logic [3:0] code, input int base, input int p, output int s);
        exp_t e;
        fill_d(p);
        cs    = code;
        start = 1'b1;
        s     = cyc + 1;
        if (base >= 0) begin
            for (int i = 0; i < WORDS; i++) begin
                e.is_done = 1'b0;
                e.cyc     = s + 1 + i;
                e.addr    = ADDR_W'(base + i);
                e.data    = pat(p, i);
                sbq.push_back(e);
            end
            e.is_done = 1'b1;
            e.cyc     = s + WORDS + 1;
            e.addr    = '0;
            e.data    = '0;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input int max);
        int n = 0;
        while (sbq.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", sbq.size(), 0);
        sbq.delete();
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < max);
        check("done_timeout", {31'b0, done}, 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("busy_eq_we", {31'b0, busy}, {31'b0, we});
            if (we || done) begin
                if (sbq.size() == 0) begin
                    check("unexpected_output", {19'b0, we, done, addr}, 0);
                end else begin
                    e = sbq.pop_front();
                    check("kind_done", {30'b0, done, we}, e.is_done ? 32'd2 : 32'd1);
                    check("cycle", cyc, e.cyc);
                    if (!e.is_done) begin
                        check("addr", {21'b0, addr}, {21'b0, e.addr});
                        check("wdata", {16'b0, wdata}, {16'b0, e.data});
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        logic [3:0] codes [5];
        int bases [5];
        codes = '{LAYER0, LAYER1, LAYER2, LAYER3, AFFINE};
        bases = '{0, 288, 576, 864, 1152};

        #2 rst = 1'b1;
        #1 check("reset_outputs", {16'b0, busy, done, we, addr, wdata[1:0]}, 0);
        check("reset_wdata", {16'b0, wdata}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // LAYER0, word i = i
        issue(LAYER0, 0, 0, s);
        wait_drain(400);
        repeat (3) @(posedge clk);
        #1;

        // AFFINE with d and cs disturbed after capture
        issue(AFFINE, 1152, 1, s);
        wait_until(s + 2);
        d = '1;
        wait_until(s + 5);
        cs = LAYER1;
        wait_drain(400);
        repeat (3) @(posedge clk);
        #1;

        // start during WRITE and during DONE state: ignored
        issue(LAYER3, 864, 2, s);
        wait_until(s + 99);
        cs = LAYER0; fill_d(3); start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_until(s + WORDS);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_drain(400);
        repeat (300) @(posedge clk);
        #1;

        // invalid layer code
        issue(4'hF, -1, 0, s);
        repeat (300) begin
            @(negedge clk);
            check("invalid_cs_idle", {29'b0, we, busy, done}, 0);
        end

        // reset mid-burst, then a fresh LAYER2 burst
        issue(LAYER2, 576, 1, s);
        wait_until(s + 149);
        rst = 1'b1;
        sbq.delete();
        #1 check("rst_mid_outputs", {29'b0, we, busy, done}, 0);
        check("rst_mid_addr", {21'b0, addr}, 0);
        check("rst_mid_wdata", {16'b0, wdata}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (400) @(posedge clk);
        #1;
        issue(LAYER2, 576, 3, s);
        wait_drain(400);
        repeat (2) @(posedge clk);
        #1;

        // back-to-back across all layers, start in the cycle done is seen
        issue(codes[0], bases[0], 0, s);
        for (int k = 1; k < 5; k++) begin
            wait_done(400);
            issue(codes[k], bases[k], k % 4, s);
        end
        wait_drain(400);
        repeat (5) @(posedge clk);
        #1 check("sb_empty", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/result_drain_23.md
# result_drain_23

Write-back counterpart to the weight store. On a `start` pulse it captures one wide 288-word result vector from the compute array and writes it word by word into a single-port RAM. The RAM region is selected by the current layer code `cs`. `done` is pulsed when the last word has been written, which lets the layer sequencer advance `cs`.

## Interface

Parameters:
- `WORDS`, default 288: words per vector.
- `ADDR_W`, default 11: RAM address width.

Ports (word width is `` `data_len `` from `num_data.v`):
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cs`  in  4  layer code: `LAYER0`/`LAYER1`/`LAYER2`/`LAYER3`/`AFFINE`.
- `start`  in  1  one-cycle request to capture `d` and begin writing.
- `d`  in  `WORDS*`data_len`  result vector; word i is at `d[i*`data_len +: `data_len]`.
- `busy`  out  1  high while writes are in progress.
- `done`  out  1  one-cycle pulse after the final write.
- `we`  out  1  RAM write enable.
- `addr`  out  `ADDR_W`  RAM address.
- `wdata`  out  `data_len`  RAM write data.

## Operation

- FSM states: IDLE, WRITE, DONE.
- **IDLE**
  - On `start` with a valid layer code:
    - latch all of `d` into an internal `WORDS`-entry shadow array;
    - latch `base` from `cs`: LAYER0 → 0, LAYER1 → 288, LAYER2 → 576, LAYER3 → 864, AFFINE → 1152;
    - clear `idx`;
    - go to WRITE.
  - On `start` with any other code: ignored, no write occurs, stay in IDLE.
- **WRITE**, each cycle:
  - `we`=1, `addr`=`base+idx`, `wdata`=`shadow[idx]`, then `idx`+1;
  - after the write with `idx`=`WORDS-1`, go to DONE.
- **DONE**: `done`=1 and `we`=0 for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored. This includes `start` in the DONE cycle.
- `cs` and `d` are don't-care after capture. A `cs` change mid-write does not alter `base`.
- `addr` arithmetic is `ADDR_W` bits with no wrap. The maximum address is 1152+287 = 1439 < 2048.
- `idx` is a 9-bit counter.

## Timing

- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `we`=0, `addr`=0, `wdata`=0, state = IDLE, `idx`=0.
- With `start` sampled at edge 0:
  - the first write (`idx` 0) is presented in cycle 1;
  - the last write (`idx` 287) is presented in cycle 288;
  - `done` is high in cycle 289;
  - the earliest next `start` is accepted in cycle 290.
- `busy` is high in cycles 1..288 and equals `we`.
- The RAM samples `we`/`addr`/`wdata` at the next rising edge.
- Asserting `rst` at any time forces all outputs to their reset values immediately. The partial write is abandoned and `done` is not pulsed. After reset is released the block waits in IDLE for a new `start`.

## Structure

- Layer codes come from `state_layer_data.v` and `` `data_len `` from `num_data.v`.
- Add `` `LAYER0_BASE `` … `` `AFFINE_BASE `` to `state_layer_data.v`, shared with the weight-store address logic.
- One sub-module, `layer_base_dec_23`: combinational decode `cs` → {`base[ADDR_W-1:0]`, `valid_code`}. The weight stores may reuse it.
- The shadow array and `idx` counter stay in the top module. The RAM is external.

## Test plan

- Reset, then `cs`=LAYER0 and `start` with `d` word i = i → `we` high in cycles 1..288, `addr` 0..287, `wdata` = `addr`, `done` in cycle 289 only.
- `cs`=AFFINE and `start`, with `d` changed to all ones in cycle 2 and `cs` changed to LAYER1 in cycle 5 → `addr` 1152..1439 and `wdata` equal to the originally captured values.
- `start` asserted during WRITE (cycle 100) and during the DONE cycle → no restart: still 288 writes and a single `done`.
- `start` with an invalid `cs`=4'hF → `we`, `busy` and `done` stay 0 for 300 cycles.
- `rst` pulsed in cycle 150 of LAYER2 writes → `we`=0 immediately and no `done`. A fresh LAYER2 `start` after release → `addr` 576..863 complete.
- Back-to-back LAYER0..AFFINE sequence with `start` issued the cycle after each `done` → 5×288 writes with contiguous addresses 0..1439 and no gaps inside any burst.
